uart_prog_loader: RTL and testbench

UART boot loader for the BrqRV_EB1 user project. It receives a little-endian stream of 32-bit instruction words on an mprj_io serial input and writes each word into core instruction memory. It holds the core in reset until a terminator word arrives. It is the receiving end of the bench-side UART programmer, which waits for `prog_ready_o` (routed to mprj_io[37]) and then shifts the program hex out on mprj_io[5].

---
 rtl/uart_prog_loader.sv | 108 ++++++++++
 tb/tb_uart_prog_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: 8N1 UART receiver that assembles little-endian 32-bit words into instruction memory
// and holds the core in reset until the terminator word arrives.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 347,
  parameter int          ADDR_W       = 12,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              rx_i,
  output logic              prog_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_rst_l_o,
  output logic              done_o,
  output logic              frame_err_o,
  output logic [ADDR_W-1:0] word_count_o
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic {LD_RECV, LD_DONE} ld_t;
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
  rx_t rx_st, rx_nxt;
  ld_t ld_st, ld_nxt;
  logic rx_m, rx_s, rx_p;
  logic [15:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic tick, byte_vld, ferr_set, last, we, ready, ferr;
  logic [1:0] byte_idx;
  logic [23:0] low;
  logic [31:0] full, wdata;
  logic [ADDR_W-1:0] addr;
  // rx_p holds the previous synchronized sample for start-edge detection
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) {rx_p, rx_s, rx_m} <= 3'b111;
    else {rx_p, rx_s, rx_m} <= {rx_s, rx_m, rx_i};
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      rx_st <= RX_IDLE;
      ld_st <= LD_RECV;
    end else begin
      rx_st <= rx_nxt;
      ld_st <= ld_nxt;
    end
  always_comb begin
    tick = cnt == 16'd1;
    rx_nxt = rx_st;
    byte_vld = 1'b0;
    ferr_set = 1'b0;
    case (rx_st)
      RX_IDLE:  if (rx_p && !rx_s) rx_nxt = RX_START;
      RX_START: if (tick) rx_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 3'd7) rx_nxt = RX_STOP;
      RX_STOP:  if (tick) begin
        rx_nxt = RX_IDLE;
        byte_vld = rx_s;
        ferr_set = !rx_s;
      end
      default:  rx_nxt = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      cnt <= HALF;
      bit_cnt <= 3'd0;
      sh <= 8'd0;
    end else begin
      cnt <= (rx_st == RX_IDLE) ? HALF : tick ? FULL : cnt - 16'd1;
      bit_cnt <= (rx_st != RX_DATA) ? 3'd0 : bit_cnt + 3'(tick);
      if (rx_st == RX_DATA && tick) sh <= {rx_s, sh[7:1]};
    end
  always_comb begin
    last = byte_vld && ld_st == LD_RECV && byte_idx == 2'd3;
    full = {sh, low};
    ld_nxt = (last && full == END_WORD) ? LD_DONE : ld_st;
  end
  // The fourth byte never lands in low; it goes straight into the compared/written word
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      byte_idx <= 2'd0;
      low <= 24'd0;
      we <= 1'b0;
      wdata <= 32'd0;
      addr <= '0;
      ferr <= 1'b0;
      ready <= 1'b0;
    end else begin
      if (byte_vld && ld_st == LD_RECV) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx != 2'd3) low[{byte_idx, 3'b000} +: 8] <= sh;
      end
      we <= last && full != END_WORD;
      if (last && full != END_WORD) wdata <= full;
      if (we) addr <= addr + 1'b1;
      ferr <= ferr | ferr_set;
      ready <= ld_nxt == LD_RECV;
    end
  assign prog_ready_o = ready;
  assign mem_we_o = we;
  assign mem_addr_o = addr;
  assign mem_wdata_o = wdata;
  assign done_o = ld_st == LD_DONE;
  assign core_rst_l_o = ld_st == LD_DONE;
  assign frame_err_o = ferr;
  assign word_count_o = addr;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: scenario tasks driving UART frames; writes are matched against a queue of expected {addr,data}.
module tb_uart_prog_loader;
  localparam int CPB = 4;
  localparam int AW = 4;
  logic clk = 1'b0, rst_l = 1'b0, rx_i = 1'b1;
  logic prog_ready_o, mem_we_o, core_rst_l_o, done_o, frame_err_o;
  logic [AW-1:0] mem_addr_o, word_count_o;
  logic [31:0] mem_wdata_o;
  logic [AW+31:0] exp_q[$], obs_q[$];
  logic [AW+31:0] e, o;
  int total = 0, bad = 0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .END_WORD(32'h0000_0FFF)) dut (
    .clk(clk), .rst_l(rst_l), .rx_i(rx_i), .prog_ready_o(prog_ready_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .core_rst_l_o(core_rst_l_o),
    .done_o(done_o), .frame_err_o(frame_err_o), .word_count_o(word_count_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_l && mem_we_o) obs_q.push_back({mem_addr_o, mem_wdata_o});

  task send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1);
  endtask

  task do_reset;
    rst_l = 1'b0;
    rx_i = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    obs_q.delete();
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  task test_reset;
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_we_o, mem_addr_o, mem_wdata_o, prog_ready_o, core_rst_l_o, done_o, frame_err_o, word_count_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h rdy=%b crst=%b done=%b ferr=%b wc=%h want all 0",
               mem_we_o, mem_addr_o, mem_wdata_o, prog_ready_o, core_rst_l_o, done_o, frame_err_o, word_count_o);
    end
    rst_l = 1'b1;
    #1;
    total++;
    if (prog_ready_o !== 1'b0) begin bad++; $display("FAIL ready_at_release: got %b want 0", prog_ready_o); end
    @(posedge clk);
    #1;
    total++;
    if (prog_ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_edge: got %b want 1", prog_ready_o); end
    total++;
    if (core_rst_l_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL core_held: got crst=%b done=%b want 0 0", core_rst_l_o, done_o);
    end
    @(negedge clk);
    obs_q.delete();
  endtask

  task test_word_load;
    exp_q.push_back({4'd0, 32'h0000_0013});
    exp_q.push_back({4'd1, 32'h0010_0093});
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_word(32'h0000_0FFF);
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL word_load_write: got %h want %h", o, e); end
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL word_load_extra: got %0d writes want 0", obs_q.size()); end
    total++;
    if ({done_o, core_rst_l_o, prog_ready_o} !== 3'b110) begin
      bad++;
      $display("FAIL word_load_done: got done/crst/rdy=%b want 110", {done_o, core_rst_l_o, prog_ready_o});
    end
    total++;
    if (word_count_o !== 4'd2) begin bad++; $display("FAIL word_load_count: got %0d want 2", word_count_o); end
  endtask

  task test_post_done;
    send_word(32'h4433_2211);
    repeat (4) @(negedge clk);
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL post_done_writes: got %0d want 0", obs_q.size()); end
    total++;
    if ({done_o, core_rst_l_o, prog_ready_o, frame_err_o, word_count_o, mem_addr_o, mem_wdata_o}
        !== {4'b1100, 4'd2, 4'd2, 32'h0010_0093}) begin
      bad++;
      $display("FAIL post_done_hold: got done=%b crst=%b rdy=%b ferr=%b wc=%0d addr=%0d data=%h want 1 1 0 0 2 2 00100093",
               done_o, core_rst_l_o, prog_ready_o, frame_err_o, word_count_o, mem_addr_o, mem_wdata_o);
    end
  endtask

  task test_glitch_framing;
    do_reset();
    rx_i = 1'b0;
    @(negedge clk);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (frame_err_o !== 1'b0) begin bad++; $display("FAIL glitch_ferr: got %b want 0", frame_err_o); end
    send_byte(8'hAA, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (frame_err_o !== 1'b1) begin bad++; $display("FAIL frame_err_set: got %b want 1", frame_err_o); end
    exp_q.push_back({4'd0, 32'hCAFE_F00D});
    send_word(32'hCAFE_F00D);
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL glitch_frame_write: got %h want %h", o, e); end
    end
    total++;
    if (obs_q.size() != 0 || frame_err_o !== 1'b1 || word_count_o !== 4'd1) begin
      bad++;
      $display("FAIL glitch_frame_after: got extra=%0d ferr=%b wc=%0d want 0 1 1", obs_q.size(), frame_err_o, word_count_o);
    end
  endtask

  task test_wrap;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back({AW'(i), 32'h1000_0000 + 32'(i)});
      send_word(32'h1000_0000 + 32'(i));
    end
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL wrap_write: got %h want %h", o, e); end
    end
    total++;
    if (obs_q.size() != 0 || word_count_o !== 4'd1) begin
      bad++;
      $display("FAIL wrap_count: got extra=%0d wc=%0d want 0 1", obs_q.size(), word_count_o);
    end
  endtask

  task test_reset_mid_word;
    do_reset();
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    exp_q.push_back({4'd0, 32'h0403_0201});
    send_word(32'h0403_0201);
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 'x;
      total++;
      if (o !== e) begin bad++; $display("FAIL mid_reset_write: got %h want %h", o, e); end
    end
    total++;
    if (obs_q.size() != 0 || word_count_o !== 4'd1 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_after: got extra=%0d wc=%0d done=%b want 0 1 0", obs_q.size(), word_count_o, done_o);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_post_done();
    test_glitch_framing();
    test_wrap();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
